// File: rtl/decode_stage.sv
`timescale 1ns/1ps
// decode_stage
//   RV32I decode stage: splits an instruction into fields, builds its
//   sign-extended immediate, selects the source operands (with same-cycle
//   writeback bypass) and captures everything into an ID/EX register.
//   The register uses valid/ready handshakes on both sides.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   handshake with fetch
//   in_instr, in_pc     offered instruction and its address
//   ra1, ra2            register-file read addresses (rs1, rs2 fields)
//   rd1, rd2            register-file read data
//   wb_we/wb_rd/wb_data writeback port, bypassed into the operands
//   flush               drop held and offered instructions
//   out_valid/out_ready handshake with execute
//   out_*               decoded payload held in the ID/EX register
module decode_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic [4:0]  ra1,
  output logic [4:0]  ra2,
  input  logic [31:0] rd1,
  input  logic [31:0] rd2,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_rs1_val,
  output logic [31:0] out_rs2_val,
  output logic [31:0] out_imm,
  output logic [4:0]  out_rd,
  output logic [6:0]  out_opcode,
  output logic [2:0]  out_funct3,
  output logic [6:0]  out_funct7,
  output logic        out_illegal
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // FMT_NONE: legal opcode without an immediate (R-type, fence, system)
  typedef enum logic [2:0] {
    FMT_NONE,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_ILL
  } fmt_t;

  logic [6:0]  opcode;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd_field;
  fmt_t        fmt;
  logic [31:0] imm;
  logic [4:0]  rd_dec;
  logic        illegal;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic        transfer;

  assign opcode   = in_instr[6:0];
  assign rd_field = in_instr[11:7];
  assign rs1      = in_instr[19:15];
  assign rs2      = in_instr[24:20];

  assign ra1 = rs1;
  assign ra2 = rs2;

  assign in_ready = (!out_valid || out_ready) && !flush;
  assign transfer = in_valid && in_ready;

  always_comb begin
    fmt = FMT_ILL;
    case (opcode)
      OP_LOAD, OP_IMM, OP_JALR:       fmt = FMT_I;
      OP_STORE:                       fmt = FMT_S;
      OP_BRANCH:                      fmt = FMT_B;
      OP_LUI, OP_AUIPC:               fmt = FMT_U;
      OP_JAL:                         fmt = FMT_J;
      OP_REG, OP_FENCE, OP_SYSTEM:    fmt = FMT_NONE;
      default:                        fmt = FMT_ILL;
    endcase
  end

  // Shift-immediates (funct3 001/101 under OP_IMM) keep the plain I layout;
  // execute only looks at the low five bits.
  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I: imm = {{20{in_instr[31]}}, in_instr[31:20]};
      FMT_S: imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      FMT_B: imm = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                    in_instr[30:25], in_instr[11:8], 1'b0};
      FMT_U: imm = {in_instr[31:12], 12'b0};
      FMT_J: imm = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                    in_instr[20], in_instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  always_comb begin
    rd_dec  = rd_field;
    illegal = 1'b0;
    if (fmt == FMT_S || fmt == FMT_B) begin
      rd_dec = '0;
    end
    if (fmt == FMT_ILL) begin
      illegal = 1'b1;
    end
  end

  // x0 is forced to zero here so the register file need not guarantee it;
  // otherwise a writeback landing this edge wins over the stale read data.
  always_comb begin
    rs1_val = rd1;
    if (rs1 == 5'd0) begin
      rs1_val = '0;
    end else if (wb_we && (wb_rd == rs1)) begin
      rs1_val = wb_data;
    end
  end

  always_comb begin
    rs2_val = rd2;
    if (rs2 == 5'd0) begin
      rs2_val = '0;
    end else if (wb_we && (wb_rd == rs2)) begin
      rs2_val = wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (transfer) begin
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // transfer already excludes flush through in_ready, so a flushed cycle
  // never overwrites the payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_pc      <= '0;
      out_rs1_val <= '0;
      out_rs2_val <= '0;
      out_imm     <= '0;
      out_rd      <= '0;
      out_opcode  <= '0;
      out_funct3  <= '0;
      out_funct7  <= '0;
      out_illegal <= 1'b0;
    end else if (transfer) begin
      out_pc      <= in_pc;
      out_rs1_val <= rs1_val;
      out_rs2_val <= rs2_val;
      out_imm     <= imm;
      out_rd      <= rd_dec;
      out_opcode  <= opcode;
      out_funct3  <= in_instr[14:12];
      out_funct7  <= in_instr[31:25];
      out_illegal <= illegal;
    end
  end

endmodule
